// File: rtl/prio_scan_encoder.sv
// Priority scan encoder: captures a request vector and emits the index of each set bit, LSB first, one beat per cycle.
// Optional feature macro PSE_ZERO_BEAT_EN: an accepted all-zero vector yields one beat flagged on out_zero.

module prio_scan_encoder #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_vec,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_valid,
`ifdef PSE_ZERO_BEAT_EN
  output logic                 out_zero,
`endif
  input  logic                 out_ready
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   pending;

  logic           accept;
  logic           handshake;
  logic           load;
  logic [N-1:0]   pending_nxt;
  logic           valid_nxt;
  logic [W-1:0]   idx_nxt;
  logic           last_nxt;
`ifdef PSE_ZERO_BEAT_EN
  logic           zero_nxt;
`endif

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [W-1:0] lsb_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // A new vector may enter while idle, or on the handshake of the final beat.
  assign in_ready = (state == IDLE) || (out_valid && out_ready && out_last);

  // Next pending vector and the beat it will present; outputs are registered from these.
  always_comb begin
    accept      = in_valid && in_ready;
    handshake   = out_valid && out_ready;
    load        = accept || handshake;
    pending_nxt = pending;
    if (accept) begin
      pending_nxt = in_vec;
    end else if (handshake) begin
      pending_nxt = pending & (pending - N'(1));
    end
    valid_nxt = |pending_nxt;
    idx_nxt   = lsb_idx(pending_nxt);
    last_nxt  = single_bit(pending_nxt);
`ifdef PSE_ZERO_BEAT_EN
    zero_nxt = 1'b0;
    if (accept && (in_vec == '0)) begin
      valid_nxt = 1'b1;
      last_nxt  = 1'b1;
      zero_nxt  = 1'b1;
    end
`endif
  end

  // Beat registers update only on accept or handshake, so a stalled beat holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
`ifdef PSE_ZERO_BEAT_EN
      out_zero  <= 1'b0;
`endif
    end else begin
      pending <= pending_nxt;
      if (load) begin
        state     <= valid_nxt ? SCAN : IDLE;
        out_valid <= valid_nxt;
        out_idx   <= idx_nxt;
        out_last  <= last_nxt;
`ifdef PSE_ZERO_BEAT_EN
        out_zero  <= zero_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Scoreboard bench for prio_scan_encoder: an 8-bit and a 64-bit instance, directed vectors with hand-computed beats.
module tb_prio_scan_encoder;

  typedef struct {
    int idx;
    bit last;
    bit zero;
    int cyc;
  } beat_t;

  beat_t q8[$];
  beat_t q64[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  vec8 = '0;
  logic        val8 = 1'b0, ordy8 = 1'b1;
  logic        irdy8, ov8, ol8;
  logic [2:0]  oi8;
  logic [63:0] vec64 = '0;
  logic        val64 = 1'b0, ordy64 = 1'b1;
  logic        irdy64, ov64, ol64;
  logic [5:0]  oi64;
`ifdef PSE_ZERO_BEAT_EN
  logic        z8, z64;
`endif

  prio_scan_encoder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_vec(vec8), .in_valid(val8), .in_ready(irdy8),
    .out_idx(oi8), .out_last(ol8), .out_valid(ov8),
`ifdef PSE_ZERO_BEAT_EN
    .out_zero(z8),
`endif
    .out_ready(ordy8)
  );

  prio_scan_encoder #(.N(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_vec(vec64), .in_valid(val64), .in_ready(irdy64),
    .out_idx(oi64), .out_last(ol64), .out_valid(ov64),
`ifdef PSE_ZERO_BEAT_EN
    .out_zero(z64),
`endif
    .out_ready(ordy64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor state per instance (0 = N8, 1 = N64)
  bit stall [2];
  int pidx  [2];
  bit plast [2];

  task automatic mon(input int w, input logic v, input logic r, input int idx, input logic last
`ifdef PSE_ZERO_BEAT_EN
                     , input logic zero
`endif
                    );
    beat_t e;
    int    qs;
    if (stall[w]) begin
      chk("hold_valid", 64'(v), 64'(1));
      chk("hold_idx", 64'(idx), 64'(pidx[w]));
      chk("hold_last", 64'(last), 64'(plast[w]));
    end
    if (!v) chk("idle_idx_zero", 64'(idx), 64'(0));
    if (v && r) begin
      qs = (w == 0) ? q8.size() : q64.size();
      if (qs == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat dut%0d at cycle %0d: got idx %0d, expected no beat", w, cyc, idx);
      end else begin
        if (w == 0) e = q8.pop_front();
        else        e = q64.pop_front();
        chk("beat_idx", 64'(idx), 64'(e.idx));
        chk("beat_last", 64'(last), 64'(e.last));
`ifdef PSE_ZERO_BEAT_EN
        chk("beat_zero", 64'(zero), 64'(e.zero));
`endif
        if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    stall[w] = v && !r;
    pidx[w]  = idx;
    plast[w] = last;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ov8, ordy8, int'(oi8), ol8
`ifdef PSE_ZERO_BEAT_EN
          , z8
`endif
         );
      mon(1, ov64, ordy64, int'(oi64), ol64
`ifdef PSE_ZERO_BEAT_EN
          , z64
`endif
         );
    end else begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push8(input int idx, input bit last, input bit zero, input int c);
    beat_t b;
    b.idx = idx; b.last = last; b.zero = zero; b.cyc = c;
    q8.push_back(b);
  endtask

  task automatic push64(input int idx, input bit last, input int c);
    beat_t b;
    b.idx = idx; b.last = last; b.zero = 1'b0; b.cyc = c;
    q64.push_back(b);
  endtask

  // Present one vector for a single accepting edge; returns one cycle later.
  task automatic send8(input logic [7:0] v);
    vec8 = v;
    val8 = 1'b1;
    @(negedge clk);
    chk("accept_ready8", 64'(irdy8), 64'(1));
    tick(1);
    val8 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] v);
    vec64 = v;
    val64 = 1'b1;
    @(negedge clk);
    chk("accept_ready64", 64'(irdy64), 64'(1));
    tick(1);
    val64 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    logic [63:0] v64;

    // Reset state
    tick(2);
    chk("rst_valid8", 64'(ov8), 64'(0));
    chk("rst_idx8", 64'(oi8), 64'(0));
    chk("rst_last8", 64'(ol8), 64'(0));
    chk("rst_valid64", 64'(ov64), 64'(0));
    chk("rst_idx64", 64'(oi64), 64'(0));
`ifdef PSE_ZERO_BEAT_EN
    chk("rst_zero8", 64'(z8), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_ready8", 64'(irdy8), 64'(1));
    chk("post_rst_ready64", 64'(irdy64), 64'(1));

    // 1010_0100 -> 2, 5, 7(last) on consecutive cycles
    c = cyc;
    push8(2, 0, 0, c + 1); push8(5, 0, 0, c + 2); push8(7, 1, 0, c + 3);
    send8(8'hA4);
    tick(4);

    // 0x81 with out_ready low three cycles: idx 0 held, then 0, then 7(last)
    ordy8 = 1'b0;
    c = cyc;
    push8(0, 0, 0, c + 4); push8(7, 1, 0, c + 5);
    send8(8'h81);
    @(negedge clk);
    chk("stall_not_ready", 64'(irdy8), 64'(0));
    tick(3);
    ordy8 = 1'b1;
    tick(3);

    // 0x03 then 0x80 with continuous in_valid: 0, 1, 7, second accept on last beat
    c = cyc;
    push8(0, 0, 0, c + 1); push8(1, 1, 0, c + 2); push8(7, 1, 0, c + 3);
    vec8 = 8'h03;
    val8 = 1'b1;
    tick(1);
    vec8 = 8'h80;
    @(negedge clk);
    chk("b2b_blocked", 64'(irdy8), 64'(0));
    tick(1);
    @(negedge clk);
    chk("b2b_ready_on_last", 64'(irdy8), 64'(1));
    tick(1);
    val8 = 1'b0;
    tick(3);

    // All-zero vector
    c = cyc;
`ifdef PSE_ZERO_BEAT_EN
    push8(0, 1, 1, c + 1);
`endif
    send8(8'h00);
    @(negedge clk);
`ifndef PSE_ZERO_BEAT_EN
    chk("zero_no_valid", 64'(ov8), 64'(0));
`endif
    chk("zero_ready", 64'(irdy8), 64'(1));
    tick(2);

    // Single-bit boundaries and a full vector
    c = cyc;
    push8(7, 1, 0, c + 1);
    send8(8'h80);
    tick(2);
    c = cyc;
    push8(0, 1, 0, c + 1);
    send8(8'h01);
    tick(2);
    c = cyc;
    for (int i = 0; i < 8; i++) push8(i, i == 7, 0, c + 1 + i);
    send8(8'hFF);
    tick(9);

    // Reset mid-scan of 0xFF, then 0x10 -> single beat idx 4
    c = cyc;
    push8(0, 0, 0, c + 1); push8(1, 0, 0, c + 2);
    send8(8'hFF);
    tick(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ov8), 64'(0));
    chk("async_rst_idx", 64'(oi8), 64'(0));
    chk("async_rst_last", 64'(ol8), 64'(0));
    tick(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready_again", 64'(irdy8), 64'(1));
    chk("rst_discarded", 64'(ov8), 64'(0));
    c = cyc;
    push8(4, 1, 0, c + 1);
    send8(8'h10);
    tick(3);

    // N=64: only bit 63, then bits 0 and 63
    c = cyc;
    push64(63, 1, c + 1);
    v64 = 64'h8000_0000_0000_0000;
    send64(v64);
    tick(2);
    c = cyc;
    push64(0, 0, c + 1); push64(63, 1, c + 2);
    v64 = 64'h8000_0000_0000_0001;
    send64(v64);
    tick(3);

    for (int i = 0; i < 20; i++) begin
      if (q8.size() == 0 && q64.size() == 0) break;
      tick(1);
    end
    chk("q8_drained", 64'(q8.size()), 64'(0));
    chk("q64_drained", 64'(q64.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prio_scan_encoder.md
PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001: Parameter N, default 8, meaning input vector width; legal range 2..64.
REQ-002: Derived localparam W, value $clog2(N), meaning index width; not overridable.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: in_vec  input  N  request vector; bit i set means index i is to be emitted.
REQ-006: in_valid  input  1  in_vec is valid this cycle.
REQ-007: in_ready  output  1  block accepts in_vec this cycle.
REQ-008: out_idx  output  W  encoded index of the current beat.
REQ-009: out_last  output  1  current beat is the final beat for the captured vector.
REQ-010: out_valid  output  1  out_idx/out_last are valid.
REQ-011: out_ready  input  1  downstream accepts the current beat.
REQ-012: out_zero  output  1  present only when PSE_ZERO_BEAT_EN is defined; flags the beat generated for an all-zero vector.

Function
REQ-013: The block SHALL have a two-state FSM, IDLE and SCAN, and an N-bit pending register.
REQ-014: Accept SHALL occur when in_valid && in_ready; on accept, pending loads in_vec.
REQ-015: in_ready SHALL be 1 in IDLE, and 1 in SCAN only when out_valid && out_ready && out_last (back-to-back accept on the final beat); otherwise 0.
REQ-016: IDLE -> SCAN on accept of a nonzero vector; an accepted zero vector is handled per REQ-026/REQ-027.
REQ-017: In SCAN, out_valid SHALL be 1, out_idx SHALL be the index of the lowest set bit of pending (LSB-first priority), and out_last SHALL be 1 when pending has exactly one bit set.
REQ-018: On a beat handshake (out_valid && out_ready), the bit at out_idx SHALL be cleared in pending on the next edge.
REQ-019: On a handshake with out_last=1: if a new nonzero vector is accepted in the same cycle, remain in SCAN with pending loaded; otherwise go to IDLE.
REQ-020: While out_valid && !out_ready, out_idx, out_last, and pending SHALL hold stable.
REQ-021: Latency SHALL be 1 cycle from accept to first out_valid; with out_ready held at 1, a vector with k set bits SHALL emit k beats on k consecutive cycles.
REQ-022: Sustained throughput SHALL be 1 beat per cycle, including across vector boundaries.
REQ-023: Outputs other than in_ready SHALL derive only from registered state, with no combinational path from in_vec/in_valid.
REQ-024: out_idx SHALL be 0 whenever out_valid=0.

Reset
REQ-025: On rst_n low, asynchronously and regardless of state: FSM=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, out_zero=0; in_ready=1 after rst_n deasserts. A vector mid-scan is discarded.

Configuration
REQ-026: With PSE_ZERO_BEAT_EN defined, an accepted all-zero vector SHALL produce exactly one beat with out_idx=0, out_last=1, out_zero=1; out_zero SHALL be 0 on all other beats.
REQ-027: Without PSE_ZERO_BEAT_EN, an accepted all-zero vector SHALL be consumed silently: no beat, the FSM stays in or returns to IDLE, and port out_zero is absent.

Verification
REQ-028: N=8, in_vec=8'b1010_0100 accepted, out_ready=1 -> beats idx 2,5,7 on 3 consecutive cycles, out_last only on idx 7.
REQ-029: N=8, in_vec=8'h81, out_ready low for 3 cycles after out_valid -> idx 0 held stable for 3 cycles, then idx 0, then idx 7 with last=1.
REQ-030: Two vectors 8'h03 then 8'h80 with in_valid continuous and out_ready=1 -> beats 0,1,7 on consecutive cycles, second accept on the last-beat cycle of the first.
REQ-031: in_vec=8'h00 accepted -> with macro: one beat idx 0, last=1, zero=1; without macro: no out_valid, in_ready stays 1.
REQ-032: rst_n pulsed low mid-scan of 8'hFF -> out_valid=0 immediately, pending cleared, next accept of 8'h10 yields a single beat idx 4 with last=1.
REQ-033: N=64, in_vec with only bit 63 set -> one beat, idx 63 (W=6), last=1, latency 1 cycle.
